// File: rtl/qc_ldpc_pkg.sv
// qc_ldpc_pkg
//   Shared constants and types for the layered QC-LDPC decoder control path.
//   Holds the base-matrix geometry (NB block columns, MB layers, KB
//   information blocks, lifting size Z), the derived counter widths and the
//   sequencer state encoding.
//   No ports; imported by the control path and its counter sub-module.
package qc_ldpc_pkg;

  localparam int NB           = 41;
  localparam int MB           = 17;
  localparam int KB           = 24;
  localparam int Z            = 87;
  localparam int MAX_ITER_DEF = 10;

  localparam int COL_W   = $clog2(NB);
  localparam int LAYER_W = $clog2(MB);
  localparam int ITER_W  = $clog2(MAX_ITER_DEF + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_SYN   = 3'd4,
    ST_OUT   = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

endpackage

// File: rtl/qc_ldpc_mod_counter.sv
// qc_ldpc_mod_counter
//   Registered modulo counter used for the column, layer and iteration
//   indices of the decoder sequencer. Counts 0..TERM; an increment while at
//   TERM returns to 0, so the count never goes past its terminal value.
//   Ports:
//     i_clk      rising-edge clock
//     i_rst_n    asynchronous active-low reset (count -> 0)
//     i_clear    synchronous clear, has priority over i_inc
//     i_inc      advance the count by one
//     o_count    current count (WIDTH bits)
//     o_at_term  count equals TERM exactly
module qc_ldpc_mod_counter
  import qc_ldpc_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int TERM  = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count,
  output logic             o_at_term
);

  localparam logic [WIDTH-1:0] TERM_V = WIDTH'(TERM);

  logic [WIDTH-1:0] r_count;
  logic             w_at_term;

  assign w_at_term = (r_count == TERM_V);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= w_at_term ? '0 : r_count + 1'b1;
    end
  end

  assign o_count   = r_count;
  assign o_at_term = w_at_term;

endmodule

// File: rtl/qc_ldpc_decoder_control_path.sv
// qc_ldpc_decoder_control_path
//   Moore sequencer for a layered QC-LDPC decoder. For each codeword it loads
//   NB channel-LLR blocks, runs layered read/write sweeps over all NB block
//   columns of each of the MB layers, evaluates the MB syndrome rows with
//   early termination, and finally streams NB hard-decision blocks out.
//   It only produces strobes and addresses; the datapath lives elsewhere.
//   Ports:
//     i_clk, i_rst_n        clock, asynchronous active-low reset
//     i_start               begin a codeword (only honoured in IDLE)
//     i_in_valid/o_in_ready channel-LLR block handshake
//     o_llr_wr_en           write LLR block at o_col_addr
//     o_col_addr            current block column
//     o_layer_addr          current layer / syndrome row
//     o_vn_rd_en/o_vn_wr_en layered sweep read / write strobes
//     o_syn_en              evaluate syndrome row o_layer_addr
//     i_syndrome_fail       that row is unsatisfied (same cycle as o_syn_en)
//     o_out_valid/i_out_ready hard-decision block handshake
//     o_iter_count          completed iterations
//     o_decode_ok           all parity rows satisfied at exit
//     o_busy, o_done        activity flag, one-cycle completion pulse
module qc_ldpc_decoder_control_path #(
  parameter int NB       = qc_ldpc_pkg::NB,
  parameter int MB       = qc_ldpc_pkg::MB,
  parameter int MAX_ITER = qc_ldpc_pkg::MAX_ITER_DEF
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_start,
  input  logic                          i_in_valid,
  output logic                          o_in_ready,
  output logic                          o_llr_wr_en,
  output logic [$clog2(NB)-1:0]         o_col_addr,
  output logic [$clog2(MB)-1:0]         o_layer_addr,
  output logic                          o_vn_rd_en,
  output logic                          o_vn_wr_en,
  output logic                          o_syn_en,
  input  logic                          i_syndrome_fail,
  output logic                          o_out_valid,
  input  logic                          i_out_ready,
  output logic [$clog2(MAX_ITER+1)-1:0] o_iter_count,
  output logic                          o_decode_ok,
  output logic                          o_busy,
  output logic                          o_done
);

  import qc_ldpc_pkg::*;

  localparam int CW = $clog2(NB);
  localparam int LW = $clog2(MB);
  localparam int IW = $clog2(MAX_ITER + 1);

  state_t          r_state;
  state_t          w_next;
  logic            r_fail;
  logic            r_decode_ok;

  logic [CW-1:0]   w_col;
  logic [LW-1:0]   w_layer;
  logic [IW-1:0]   w_iter;
  logic            w_col_term;
  logic            w_layer_term;
  logic            w_iter_term;

  logic            w_start;
  logic            w_in_xfer;
  logic            w_out_xfer;
  logic            w_col_inc;
  logic            w_layer_inc;
  logic            w_iter_inc;
  logic            w_syn_last;
  logic            w_fail_any;

  assign w_start    = (r_state == ST_IDLE) && i_start;
  assign w_in_xfer  = (r_state == ST_LOAD) && i_in_valid;
  assign w_out_xfer = (r_state == ST_OUT) && i_out_ready;

  // The column counter wraps to 0 at NB-1, which is exactly the column
  // value every phase transition needs, so no extra clears are required.
  assign w_col_inc = w_in_xfer || w_out_xfer ||
                     (r_state == ST_READ) || (r_state == ST_WRITE);

  // Layer advances once per completed write sweep, and once per syndrome
  // row; both wrap back to 0 at MB-1.
  assign w_layer_inc = ((r_state == ST_WRITE) && w_col_term) ||
                       (r_state == ST_SYN);

  assign w_iter_inc = (r_state == ST_WRITE) && w_col_term && w_layer_term;

  assign w_syn_last = (r_state == ST_SYN) && w_layer_term;

  // Include the current row so the last syndrome row is not lost.
  assign w_fail_any = r_fail || i_syndrome_fail;

  qc_ldpc_mod_counter #(.WIDTH(CW), .TERM(NB - 1)) u_col_cnt (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (w_start),
    .i_inc     (w_col_inc),
    .o_count   (w_col),
    .o_at_term (w_col_term)
  );

  qc_ldpc_mod_counter #(.WIDTH(LW), .TERM(MB - 1)) u_layer_cnt (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (w_start),
    .i_inc     (w_layer_inc),
    .o_count   (w_layer),
    .o_at_term (w_layer_term)
  );

  // The iteration count only increments while below MAX_ITER: at MAX_ITER
  // the syndrome phase always exits to OUT, so it never wraps.
  qc_ldpc_mod_counter #(.WIDTH(IW), .TERM(MAX_ITER)) u_iter_cnt (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (w_start),
    .i_inc     (w_iter_inc),
    .o_count   (w_iter),
    .o_at_term (w_iter_term)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_next = ST_LOAD;
      ST_LOAD:  if (i_in_valid && w_col_term) w_next = ST_READ;
      ST_READ:  if (w_col_term) w_next = ST_WRITE;
      ST_WRITE: if (w_col_term) w_next = w_layer_term ? ST_SYN : ST_READ;
      ST_SYN: begin
        if (w_layer_term) begin
          if (!w_fail_any || w_iter_term) w_next = ST_OUT;
          else                            w_next = ST_READ;
        end
      end
      ST_OUT:   if (i_out_ready && w_col_term) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Sticky per-iteration syndrome failure, cleared as the iteration's last
  // write sweep finishes so each syndrome pass starts clean.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fail <= 1'b0;
    end else if (w_iter_inc) begin
      r_fail <= 1'b0;
    end else if (r_state == ST_SYN) begin
      r_fail <= r_fail | i_syndrome_fail;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_decode_ok <= 1'b0;
    end else if (w_start) begin
      r_decode_ok <= 1'b0;
    end else if (w_syn_last) begin
      r_decode_ok <= !w_fail_any;
    end
  end

  assign o_in_ready   = (r_state == ST_LOAD);
  assign o_llr_wr_en  = w_in_xfer;
  assign o_col_addr   = w_col;
  assign o_layer_addr = w_layer;
  assign o_vn_rd_en   = (r_state == ST_READ);
  assign o_vn_wr_en   = (r_state == ST_WRITE);
  assign o_syn_en     = (r_state == ST_SYN);
  assign o_out_valid  = (r_state == ST_OUT);
  assign o_iter_count = w_iter;
  assign o_decode_ok  = r_decode_ok;
  assign o_busy       = (r_state != ST_IDLE);
  assign o_done       = (r_state == ST_DONE);

endmodule

// File: tb/tb_qc_ldpc_decoder_control_path.sv
// tb_qc_ldpc_decoder_control_path
//   Self-checking bench for the QC-LDPC decoder control path. A queue of
//   expected strobe events (kind, layer, column) is built per codeword from
//   the decoding rules; a per-cycle process drives the handshakes and the
//   syndrome response and consumes that queue as the DUT emits strobes.
module tb_qc_ldpc_decoder_control_path;

  localparam int NB       = 41;
  localparam int MB       = 17;
  localparam int MAX_ITER = 10;

  localparam int K_LLR = 1;
  localparam int K_RD  = 2;
  localparam int K_WR  = 3;
  localparam int K_SYN = 4;
  localparam int K_OUT = 5;

  typedef struct {
    int kind;
    int layer;
    int col;
  } evt_t;

  logic       clk;
  logic       i_rst_n;
  logic       i_start;
  logic       i_in_valid;
  logic       i_out_ready;
  logic       i_syndrome_fail;
  logic       o_in_ready;
  logic       o_llr_wr_en;
  logic [5:0] o_col_addr;
  logic [4:0] o_layer_addr;
  logic       o_vn_rd_en;
  logic       o_vn_wr_en;
  logic       o_syn_en;
  logic       o_out_valid;
  logic [3:0] o_iter_count;
  logic       o_decode_ok;
  logic       o_busy;
  logic       o_done;

  evt_t expQ[$];
  int   expIter;
  int   expOk;

  int total;
  int bad;

  int cycleNo;
  int startCycle;
  int doneCycle;
  int rstHold;
  bit startReq;
  bit startPending;
  bit runActive;
  bit doneSeen;
  bit abortArmed;
  bit abortHit;
  int synModeG;
  bit stallMode;
  bit startNoise;
  bit stallDone;
  int stallLeft;

  int llrCnt;
  int rdCnt;
  int wrCnt;
  int synCnt;
  int outCnt;
  int outValidCyc;
  int doneCnt;

  qc_ldpc_decoder_control_path dut (
    .i_clk           (clk),
    .i_rst_n         (i_rst_n),
    .i_start         (i_start),
    .i_in_valid      (i_in_valid),
    .o_in_ready      (o_in_ready),
    .o_llr_wr_en     (o_llr_wr_en),
    .o_col_addr      (o_col_addr),
    .o_layer_addr    (o_layer_addr),
    .o_vn_rd_en      (o_vn_rd_en),
    .o_vn_wr_en      (o_vn_wr_en),
    .o_syn_en        (o_syn_en),
    .i_syndrome_fail (i_syndrome_fail),
    .o_out_valid     (o_out_valid),
    .i_out_ready     (i_out_ready),
    .o_iter_count    (o_iter_count),
    .o_decode_ok     (o_decode_ok),
    .o_busy          (o_busy),
    .o_done          (o_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cycleNo);
    end
  endtask

  // Syndrome scenarios: 0 always clean, 1 row 5 fails forever,
  // 2 row 0 fails in iteration 1 and row 16 (the last row) in iteration 2.
  function automatic bit failFn(int mode, int it, int row);
    case (mode)
      1:       return (row == 5);
      2:       return (it == 1 && row == 0) || (it == 2 && row == MB - 1);
      default: return 1'b0;
    endcase
  endfunction

  function automatic void pushEvt(int kind, int layer, int col);
    evt_t e;
    e.kind  = kind;
    e.layer = layer;
    e.col   = col;
    expQ.push_back(e);
  endfunction

  // Expected strobe sequence for one codeword; layer -1 means unchecked.
  function automatic void buildExpected(int mode);
    bit anyFail;
    expQ.delete();
    for (int c = 0; c < NB; c++) pushEvt(K_LLR, -1, c);
    for (int it = 1; it <= MAX_ITER; it++) begin
      for (int l = 0; l < MB; l++) begin
        for (int c = 0; c < NB; c++) pushEvt(K_RD, l, c);
        for (int c = 0; c < NB; c++) pushEvt(K_WR, l, c);
      end
      anyFail = 1'b0;
      for (int r = 0; r < MB; r++) begin
        pushEvt(K_SYN, r, 0);
        if (failFn(mode, it, r)) anyFail = 1'b1;
      end
      if (!anyFail) begin
        expIter = it;
        expOk   = 1;
        break;
      end
      if (it == MAX_ITER) begin
        expIter = it;
        expOk   = 0;
      end
    end
    for (int c = 0; c < NB; c++) pushEvt(K_OUT, -1, c);
  endfunction

  function automatic int headKind();
    return (expQ.size() > 0) ? expQ[0].kind : 0;
  endfunction

  task automatic doCycleChecks();
    int   nEv;
    int   gotKind;
    int   actCode;
    int   expCode;
    evt_t e;
    bit   outXfer;
    outXfer = o_out_valid && i_out_ready;
    nEv = int'(o_llr_wr_en) + int'(o_vn_rd_en) + int'(o_vn_wr_en) + int'(o_syn_en) + int'(outXfer);
    if (!runActive) begin
      checkOutput("idle_quiet",
                  int'({o_in_ready, o_llr_wr_en, o_vn_rd_en, o_vn_wr_en, o_syn_en, o_out_valid, o_busy, o_done}), 0);
    end else begin
      checkOutput("busy", int'(o_busy), 1);
      checkOutput("in_ready", int'(o_in_ready), int'(headKind() == K_LLR));
      if (nEv > 1) checkOutput("one_strobe", nEv, 1);
      if (nEv == 1) begin
        gotKind = o_llr_wr_en ? K_LLR : o_vn_rd_en ? K_RD : o_vn_wr_en ? K_WR : o_syn_en ? K_SYN : K_OUT;
        if (expQ.size() == 0) begin
          checkOutput("extra_event", gotKind, 0);
        end else begin
          e = expQ.pop_front();
          expCode = e.kind * 10000 + ((e.layer >= 0) ? e.layer : 0) * 100 + e.col;
          actCode = gotKind * 10000 + ((e.layer >= 0) ? int'(o_layer_addr) : 0) * 100 + int'(o_col_addr);
          checkOutput("event", actCode, expCode);
        end
        case (gotKind)
          K_LLR:   llrCnt++;
          K_RD:    rdCnt++;
          K_WR:    wrCnt++;
          K_SYN:   synCnt++;
          default: outCnt++;
        endcase
      end
      if (o_out_valid && !i_out_ready) begin
        expCode = (headKind() == K_OUT) ? expQ[0].col : -1;
        checkOutput("stall_col", int'(o_col_addr), expCode);
      end
      if (o_out_valid) outValidCyc++;
      if (o_done) begin
        checkOutput("done_queue_empty", expQ.size(), 0);
        checkOutput("done_iter", int'(o_iter_count), expIter);
        checkOutput("done_ok", int'(o_decode_ok), expOk);
        doneCnt++;
        doneCycle = cycleNo - startCycle;
        doneSeen  = 1'b1;
        runActive = 1'b0;
      end
    end
  endtask

  // Per-cycle driver and checker: inputs change at the falling edge, outputs
  // are checked 1 time unit later, well away from the rising edge.
  initial begin
    cycleNo = 0;
    forever begin
      @(negedge clk);
      cycleNo++;
      if (rstHold > 0) begin
        rstHold--;
        if (rstHold == 0) i_rst_n = 1'b1;
      end else begin
        if (startPending) begin
          runActive    = 1'b1;
          startPending = 1'b0;
        end
        if (startReq) begin
          i_start      = 1'b1;
          startReq     = 1'b0;
          startCycle   = cycleNo;
          startPending = 1'b1;
        end else begin
          i_start = startNoise && (o_vn_rd_en || o_syn_en);
        end
        i_in_valid = stallMode ? ((cycleNo % 2) == 0) : 1'b1;
        if (stallMode && !stallDone && o_out_valid && o_col_addr == 6'd20) begin
          stallLeft = 5;
          stallDone = 1'b1;
        end
        i_out_ready = (stallLeft == 0);
        if (stallLeft > 0) stallLeft--;
        i_syndrome_fail = o_syn_en && failFn(synModeG, synCnt / MB + 1, int'(o_layer_addr));
        #1;
        if (abortArmed && o_vn_wr_en && o_layer_addr == 5'd8) begin
          i_rst_n = 1'b0;
          i_start = 1'b0;
          #1;
          checkOutput("abort_strobes",
                      int'({o_in_ready, o_llr_wr_en, o_vn_rd_en, o_vn_wr_en, o_syn_en,
                            o_out_valid, o_busy, o_done, o_decode_ok}), 0);
          checkOutput("abort_addr", int'({o_col_addr, o_layer_addr, o_iter_count}), 0);
          expQ.delete();
          runActive  = 1'b0;
          abortArmed = 1'b0;
          abortHit   = 1'b1;
          rstHold    = 2;
        end else begin
          doCycleChecks();
        end
      end
    end
  end

  task automatic applyStimulus(input int synMode, input bit stall, input bit noise, input bit abortRun);
    buildExpected(synMode);
    synModeG    = synMode;
    stallMode   = stall;
    startNoise  = noise;
    stallDone   = 1'b0;
    stallLeft   = 0;
    llrCnt      = 0;
    rdCnt       = 0;
    wrCnt       = 0;
    synCnt      = 0;
    outCnt      = 0;
    outValidCyc = 0;
    doneCnt     = 0;
    doneSeen    = 1'b0;
    abortHit    = 1'b0;
    abortArmed  = abortRun;
    startReq    = 1'b1;
    for (int n = 0; n < 20000 && !doneSeen && !abortHit; n++) @(posedge clk);
    if (!doneSeen && !abortHit) checkOutput("run_timeout", 0, 1);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    total           = 0;
    bad             = 0;
    i_rst_n         = 1'b0;
    i_start         = 1'b0;
    i_in_valid      = 1'b0;
    i_out_ready     = 1'b0;
    i_syndrome_fail = 1'b0;
    rstHold         = 3;
    startReq        = 1'b0;
    startPending    = 1'b0;
    runActive       = 1'b0;
    abortArmed      = 1'b0;
    abortHit        = 1'b0;
    doneSeen        = 1'b0;
    stallMode       = 1'b0;
    startNoise      = 1'b0;
    stallLeft       = 0;
    synModeG        = 0;
    synCnt          = 0;
    expIter         = 0;
    expOk           = 0;

    #2;
    checkOutput("reset_strobes",
                int'({o_in_ready, o_llr_wr_en, o_vn_rd_en, o_vn_wr_en, o_syn_en,
                      o_out_valid, o_busy, o_done, o_decode_ok}), 0);
    checkOutput("reset_addr", int'({o_col_addr, o_layer_addr, o_iter_count}), 0);
    repeat (5) @(negedge clk);

    // Hand-computed lengths and outcomes that pin the expectation model.
    buildExpected(0);
    checkOutput("model_len_clean", expQ.size(), 1493);
    buildExpected(1);
    checkOutput("model_len_noconv", expQ.size(), 14192);
    checkOutput("model_iter_noconv", expIter, 10);
    buildExpected(2);
    checkOutput("model_iter_conv3", expIter, 3);
    checkOutput("model_ok_conv3", expOk, 1);
    expQ.delete();

    $display("[TB] clean codeword");
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    checkOutput("clean_done_cycle", doneCycle, 1494);
    checkOutput("clean_llr", llrCnt, 41);
    checkOutput("clean_rd", rdCnt, 697);
    checkOutput("clean_wr", wrCnt, 697);
    checkOutput("clean_syn", synCnt, 17);
    checkOutput("clean_out", outCnt, 41);
    checkOutput("clean_iter", int'(o_iter_count), 1);
    checkOutput("clean_ok", int'(o_decode_ok), 1);
    checkOutput("clean_done_cnt", doneCnt, 1);

    $display("[TB] non-converging codeword");
    applyStimulus(1, 1'b0, 1'b0, 1'b0);
    checkOutput("noconv_syn", synCnt, 170);
    checkOutput("noconv_rd", rdCnt, 6970);
    checkOutput("noconv_out", outCnt, 41);
    checkOutput("noconv_done_cnt", doneCnt, 1);
    repeat (10) @(negedge clk);
    #2;
    checkOutput("noconv_iter_hold", int'(o_iter_count), 10);
    checkOutput("noconv_ok_hold", int'(o_decode_ok), 0);

    $display("[TB] converge at iteration 3");
    applyStimulus(2, 1'b0, 1'b0, 1'b0);
    checkOutput("conv3_syn", synCnt, 51);
    checkOutput("conv3_iter", int'(o_iter_count), 3);
    checkOutput("conv3_ok", int'(o_decode_ok), 1);

    $display("[TB] handshake stalls");
    applyStimulus(0, 1'b1, 1'b0, 1'b0);
    checkOutput("stall_llr", llrCnt, 41);
    checkOutput("stall_out", outCnt, 41);
    checkOutput("stall_valid_cycles", outValidCyc, 46);
    checkOutput("stall_happened", int'(stallDone), 1);

    $display("[TB] start noise during READ and SYN");
    applyStimulus(0, 1'b0, 1'b1, 1'b0);
    checkOutput("noise_done_cycle", doneCycle, 1494);
    checkOutput("noise_done_cnt", doneCnt, 1);
    checkOutput("noise_iter", int'(o_iter_count), 1);

    $display("[TB] reset during WRITE at layer 8");
    applyStimulus(0, 1'b0, 1'b0, 1'b1);
    checkOutput("abort_hit", int'(abortHit), 1);
    repeat (4) @(negedge clk);
    #2;
    checkOutput("abort_idle",
                int'({o_busy, o_done, o_decode_ok, o_in_ready, o_vn_rd_en, o_vn_wr_en}), 0);
    checkOutput("abort_iter", int'(o_iter_count), 0);
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    checkOutput("post_abort_done_cycle", doneCycle, 1494);
    checkOutput("post_abort_iter", int'(o_iter_count), 1);
    checkOutput("post_abort_ok", int'(o_decode_ok), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qc_ldpc_decoder_control_path.md
Name: qc_ldpc_decoder_control_path

Overview:
- FSM and counter sequencer for the layered QC-LDPC decoder, the receive-side counterpart of the QC-LDPC encoder control path.
- Sequences four phases:
  - channel-LLR load;
  - per-layer read/write sweeps over block columns;
  - syndrome check with early termination;
  - hard-decision readout.
- Drives the decoder datapath (LLR RAM, Z-wide min-sum core, syndrome unit) with strobes and addresses. Contains no datapath arithmetic.

Parameters:
- NB, 41, block columns (circulants per codeword row; matches encoder 41 total blocks).
- MB, 17, block rows / layers (NB minus 24 information blocks).
- MAX_ITER, 10, maximum decoding iterations (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a codeword; sampled only in IDLE.
- in_valid  in  1  channel-LLR block (Z values) present.
- in_ready  out  1  control accepts an LLR block.
- llr_wr_en  out  1  write LLR block to RAM at col_addr.
- col_addr  out  $clog2(NB)  current block-column index.
- layer_addr  out  $clog2(MB)  current layer / syndrome row.
- vn_rd_en  out  1  read VN LLR + CN message for (layer_addr, col_addr).
- vn_wr_en  out  1  write updated VN LLR for (layer_addr, col_addr).
- syn_en  out  1  evaluate syndrome of row layer_addr.
- syndrome_fail  in  1  row layer_addr parity unsatisfied; valid same cycle as syn_en.
- out_valid  out  1  hard-decision block at col_addr presented.
- out_ready  in  1  downstream accepts hard-decision block.
- iter_count  out  $clog2(MAX_ITER+1)  completed iterations.
- decode_ok  out  1  all parity rows satisfied at exit.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at completion.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; col, layer, iter counters=0; fail flag=0; decode_ok=0.
  - All strobes and outputs are 0.
  - Reset asserted mid-operation aborts immediately; no residual strobes after release.
- Strobes and addresses are decoded combinationally from the registered state and counters (Moore). All counters are registered.
- IDLE:
  - All strobes 0; iter_count and decode_ok hold their last values.
  - start=1 → LOAD, clear col, iter, decode_ok. start is ignored in every other state.
- LOAD:
  - in_ready=1.
  - A beat transfers when in_valid && in_ready; that cycle llr_wr_en=1 and col_addr=col; then col++.
  - in_valid=0 stalls without changing the counter.
  - Transfer at col==NB-1 → READ with col=0, layer=0.
- READ:
  - vn_rd_en=1 each cycle, no stalls, col 0..NB-1.
  - At col==NB-1 → WRITE, col=0.
- WRITE:
  - vn_wr_en=1, col 0..NB-1.
  - At col==NB-1:
    - if layer<MB-1: layer++, → READ.
    - else: iter_count++, layer=0, clear fail flag, → SYN.
- SYN:
  - syn_en=1, layer_addr=layer, 0..MB-1; fail flag |= syndrome_fail each cycle.
  - At layer==MB-1, using fail flag OR the current syndrome_fail:
    - clean → decode_ok=1, → OUT.
    - failing and iter_count==MAX_ITER → decode_ok=0, → OUT.
    - otherwise → READ with layer=0, col=0.
  - In all three cases col=0.
- OUT:
  - out_valid=1, col_addr=col.
  - col advances only on out_ready; it holds, with out_valid high, while out_ready=0.
  - Transfer at col==NB-1 → DONE.
- DONE: done=1 for exactly one cycle, → IDLE. busy deasserts the same cycle IDLE is entered.
- No phase starts a new codeword until IDLE; back-to-back start held high begins the next LOAD 1 cycle after DONE.
- Widths: col 6 bits, layer 5 bits, iter 4 bits at defaults. Terminal compares are exact equality; counters never wrap past terminal.

Decomposition:
- Package qc_ldpc_pkg holds:
  - NB, MB, KB=24, Z=87 constants;
  - the derived widths;
  - the state enum {IDLE, LOAD, READ, WRITE, SYN, OUT, DONE}.
- One sub-module: qc_ldpc_mod_counter (parameter WIDTH, TERM; inputs clear, inc; outputs count, at_term), instantiated for col, layer and iter.

Test Plan:
- Clean codeword (defaults): start at cycle 0, in_valid and out_ready held 1, syndrome_fail=0 → the following all occur, with done at cycle 1+41+1394+17+41:
  - 41 llr_wr_en beats;
  - 17×(41 vn_rd_en + 41 vn_wr_en);
  - 17 syn_en;
  - iter_count=1, decode_ok=1;
  - 41 out_valid beats.
- Non-converging: syndrome_fail=1 on row 5 every iteration → 10 full iterations, then iter_count=10, decode_ok=0, OUT entered, single done pulse.
- Converge at iteration 3: syndrome_fail=1 only during iterations 1–2 → exit after the 3rd SYN with iter_count=3, decode_ok=1.
- Handshake stalls: in_valid toggled 1,0,1… and out_ready low for 5 cycles at col=20 → col_addr holds, exactly 41 writes and 41 output beats, no duplicates or skips.
- Reset mid-operation: rst_n pulsed low during WRITE at layer 8 → all outputs 0 immediately; after release, state IDLE, and a new start produces a full clean run.
- start asserted during READ and SYN → ignored; counters and sequence unchanged.
